// File: rtl/pwm_spi_pkg.sv
// -----------------------------------------------------------------------------
// pwm_spi_pkg
// Shared definitions for the PWM command link. The transmit side
// (pwm_cmd_tx) and the receive-side register file both use this package.
//   - pwm_cmd_e   : 3-bit command codes carried in the first frame byte
//   - tx_state_e  : transmit sequencer states
//   - FRAME_LEN_* : frame lengths in bytes (command byte included)
//   - helpers     : frame length lookup and per-index frame byte selection
// -----------------------------------------------------------------------------
package pwm_spi_pkg;

  typedef enum logic [2:0] {
    CMD_NONE           = 3'd0,
    CMD_WRITE_CV       = 3'd1,
    CMD_WRITE_PRESCALE = 3'd2,
    CMD_WRITE_DC1      = 3'd3,
    CMD_WRITE_DC2      = 3'd4,
    CMD_WRITE_DC3      = 3'd5,
    CMD_DISABLE_PWM    = 3'd6,
    CMD_ENABLE_PWM     = 3'd7
  } pwm_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // Command byte plus a 32-bit payload, or the command byte alone.
  localparam logic [2:0] FRAME_LEN_PAYLOAD = 3'd5;
  localparam logic [2:0] FRAME_LEN_CTRL    = 3'd1;

  // Width of the inter-byte gap counter (gap range 0..255).
  localparam int unsigned GAP_CNT_W = 8;

  function automatic logic cmd_is_valid(input logic [2:0] cmd);
    return cmd != 3'(CMD_NONE);
  endfunction

  function automatic logic [2:0] frame_len(input logic [2:0] cmd);
    if (cmd == 3'(CMD_DISABLE_PWM) || cmd == 3'(CMD_ENABLE_PWM))
      return FRAME_LEN_CTRL;
    else
      return FRAME_LEN_PAYLOAD;
  endfunction

  // Byte 0 is the command, bytes 1..4 are the payload LSB first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  cmd,
                                            input logic [31:0] data,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {5'b0, cmd};
      3'd1:    b = data[7:0];
      3'd2:    b = data[15:8];
      3'd3:    b = data[23:16];
      3'd4:    b = data[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// -----------------------------------------------------------------------------
// byte_gap_timer
// Loadable down-counter that times the idle gap between transmitted bytes.
//   i_Clk      : clock, rising edge
//   i_Rst_L    : synchronous active-low reset, clears the count
//   i_Load     : load i_Load_Val this cycle (overrides counting)
//   i_Load_Val : number of cycles to time
//   o_Expire   : high during the last timed cycle (count == 1)
// A load of N produces exactly N cycles of nonzero count, the last of
// which asserts o_Expire. A load of 0 never expires.
// -----------------------------------------------------------------------------
module byte_gap_timer
  import pwm_spi_pkg::*;
#(
  parameter int unsigned WIDTH = GAP_CNT_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  output logic             o_Expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      count <= '0;
    end else if (i_Load) begin
      count <= i_Load_Val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign o_Expire = (count == WIDTH'(1));

endmodule

// File: rtl/pwm_cmd_tx.sv
// -----------------------------------------------------------------------------
// pwm_cmd_tx
// Serialises PWM configuration commands into byte frames for an SPI master.
// Frame: {5'b0,cmd} then data[7:0],[15:8],[23:16],[31:24] for cmds 1..5;
// the command byte alone for cmds 6/7. Cmd 0 is rejected with o_Err.
//   INTER_BYTE_GAP : extra idle cycles between consecutive bytes (0..255)
//   i_Clk          : clock, rising edge
//   i_Rst_L        : synchronous active-low reset, aborts any frame
//   i_Req_Valid    : command request present
//   i_Req_Cmd      : command code
//   i_Req_Data     : payload for cmds 1..5
//   o_Req_Ready    : request accepted this cycle if i_Req_Valid (IDLE only)
//   o_TX_DV        : one-cycle byte strobe to the SPI master
//   o_TX_Byte      : byte to shift out, 0 whenever o_TX_DV is low
//   i_TX_Ready     : SPI master can take a byte
//   o_Busy         : frame in progress
//   o_Done         : one-cycle pulse in the cycle the frame returns to IDLE
//   o_Err          : one-cycle pulse the cycle after accepting cmd 0
// Byte strobes are at least 2+INTER_BYTE_GAP cycles apart: one ISSUE
// cycle, one HOLD cycle covering the master's ready-drop latency, and
// the optional gap.
// -----------------------------------------------------------------------------
module pwm_cmd_tx
  import pwm_spi_pkg::*;
#(
  parameter int unsigned INTER_BYTE_GAP = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Req_Valid,
  input  logic [2:0]  i_Req_Cmd,
  input  logic [31:0] i_Req_Data,
  output logic        o_Req_Ready,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Ready,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err
);

  localparam logic [GAP_CNT_W-1:0] GAP_CYCLES = GAP_CNT_W'(INTER_BYTE_GAP);
  localparam bit                   HAS_GAP    = (INTER_BYTE_GAP != 0);

  tx_state_e   state, state_next;

  logic [2:0]  cmd_q;
  logic [31:0] data_q;
  logic [2:0]  idx_q;
  logic        tx_dv_q;
  logic [7:0]  tx_byte_q;
  logic        err_q;

  logic        accept;
  logic        accept_ok;
  logic        issue_now;
  logic        last_byte;
  logic        gap_load;
  logic        gap_expire;
  logic        frame_end;
  logic        idx_adv;

  assign accept    = i_Req_Valid && (state == IDLE);
  assign accept_ok = accept && cmd_is_valid(i_Req_Cmd);
  assign issue_now = (state == ISSUE) && i_TX_Ready;
  assign last_byte = (idx_q == (frame_len(cmd_q) - 3'd1));
  assign gap_load  = (state == HOLD) && HAS_GAP;

  byte_gap_timer #(
    .WIDTH (GAP_CNT_W)
  ) u_gap_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Load     (gap_load),
    .i_Load_Val (GAP_CYCLES),
    .o_Expire   (gap_expire)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // After HOLD (and after GAP when a gap is configured) the sequencer
  // either moves to the next byte or closes the frame.
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    idx_adv    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_ok) state_next = ISSUE;
      end
      ISSUE: begin
        if (i_TX_Ready) state_next = HOLD;
      end
      HOLD: begin
        if (HAS_GAP) begin
          state_next = GAP;
        end else if (last_byte) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          state_next = ISSUE;
          idx_adv    = 1'b1;
        end
      end
      GAP: begin
        if (gap_expire) begin
          if (last_byte) begin
            state_next = IDLE;
            frame_end  = 1'b1;
          end else begin
            state_next = ISSUE;
            idx_adv    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cmd_q     <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tx_dv_q   <= issue_now;
      tx_byte_q <= issue_now ? frame_byte(cmd_q, data_q, idx_q) : '0;
      err_q     <= accept && !cmd_is_valid(i_Req_Cmd);
      if (accept_ok) begin
        cmd_q  <= i_Req_Cmd;
        data_q <= i_Req_Data;
      end
      if (frame_end) begin
        idx_q <= '0;
      end else if (idx_adv) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  assign o_Req_Ready = (state == IDLE);
  assign o_Busy      = (state != IDLE);
  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Err       = err_q;
  // Done is decoded from the closing transition rather than registered so
  // that it precedes the first IDLE cycle; the next request can therefore
  // only be taken in the cycle after the pulse. Reset suppresses it.
  assign o_Done      = frame_end && i_Rst_L;

endmodule

// File: tb/tb_pwm_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_pwm_cmd_tx
// Two instances: inst0 with INTER_BYTE_GAP=0, inst1 with INTER_BYTE_GAP=3.
// Stimulus pushes expected frame bytes into per-instance queues; a monitor
// pops and compares on every o_TX_DV, checks spacing, o_Done/o_Err, and
// feeds observed frames into a receive-side register file model.
// -----------------------------------------------------------------------------
module tb_pwm_cmd_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l [2];
  logic        valid [2];
  logic [2:0]  cmd   [2];
  logic [31:0] data  [2];
  logic        txr   [2];
  logic        rdy   [2];
  logic        dv    [2];
  logic [7:0]  txb   [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];

  pwm_cmd_tx #(.INTER_BYTE_GAP(0)) dut0 (
    .i_Clk(clk), .i_Rst_L(rst_l[0]), .i_Req_Valid(valid[0]), .i_Req_Cmd(cmd[0]),
    .i_Req_Data(data[0]), .o_Req_Ready(rdy[0]), .o_TX_DV(dv[0]), .o_TX_Byte(txb[0]),
    .i_TX_Ready(txr[0]), .o_Busy(busy[0]), .o_Done(done[0]), .o_Err(err[0])
  );

  pwm_cmd_tx #(.INTER_BYTE_GAP(3)) dut1 (
    .i_Clk(clk), .i_Rst_L(rst_l[1]), .i_Req_Valid(valid[1]), .i_Req_Cmd(cmd[1]),
    .i_Req_Data(data[1]), .o_Req_Ready(rdy[1]), .o_TX_DV(dv[1]), .o_TX_Byte(txb[1]),
    .i_TX_Ready(txr[1]), .o_Busy(busy[1]), .o_Done(done[1]), .o_Err(err[1])
  );

  int unsigned gap_min [2];
  logic [7:0]  exp_mem [2][256];
  int unsigned wr_p [2];
  int unsigned rd_p [2];
  int          frames_pend [2];
  int          err_pend [2];
  bit          rdy_always [2];

  int unsigned cyc;
  int unsigned last_dv [2];
  int unsigned mon_idx [2];
  logic [7:0]  frame_buf [2][5];
  logic [31:0] rx_reg [2][8];
  bit          rx_en [2];
  int unsigned sp;
  logic [2:0]  fc;

  int compared;
  int mismatched;

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s inst%0d: got %0h, required %0h", name, d, got, want);
    end
  endtask

  task automatic fail_now(input string name, input int d);
    compared++;
    mismatched++;
    $display("FAIL %s inst%0d: bound expired", name, d);
  endtask

  // Reference framing: command byte, then the payload LSB first for 1..5.
  task automatic push_frame(input int d, input logic [2:0] c, input logic [31:0] dat);
    if (c == 3'd0) begin
      err_pend[d]++;
    end else begin
      exp_mem[d][wr_p[d] % 256] = {5'b0, c};
      wr_p[d]++;
      if (c <= 3'd5) begin
        for (int i = 0; i < 4; i++) begin
          exp_mem[d][wr_p[d] % 256] = dat[8*i +: 8];
          wr_p[d]++;
        end
      end
      frames_pend[d]++;
    end
  endtask

  task automatic flush(input int d);
    rd_p[d]        = wr_p[d];
    frames_pend[d] = 0;
    err_pend[d]    = 0;
    mon_idx[d]     = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      check("ready_vs_busy", d, rdy[d], !busy[d]);
      if (dv[d]) begin
        if (rd_p[d] == wr_p[d]) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_dv inst%0d: got byte %02h, required no byte", d, txb[d]);
        end else begin
          check("tx_byte", d, txb[d], exp_mem[d][rd_p[d] % 256]);
          rd_p[d]++;
        end
        if (mon_idx[d] != 0) begin
          sp = cyc - last_dv[d];
          compared++;
          if (rdy_always[d] ? (sp != gap_min[d]) : (sp < gap_min[d])) begin
            mismatched++;
            $display("FAIL dv_spacing inst%0d: got %0d cycles, required %s%0d", d, sp,
                     rdy_always[d] ? "" : ">=", gap_min[d]);
          end
        end
        last_dv[d] = cyc;
        if (mon_idx[d] < 5) frame_buf[d][mon_idx[d]] = txb[d];
        mon_idx[d]++;
      end else begin
        check("byte_idle_zero", d, txb[d], 32'h0);
      end
      if (done[d]) begin
        compared++;
        if (frames_pend[d] == 0 || rd_p[d] != wr_p[d]) begin
          mismatched++;
          $display("FAIL done_pulse inst%0d: got done with %0d frames pending and %0d bytes unsent, required 1 pending and 0 unsent",
                   d, frames_pend[d], wr_p[d] - rd_p[d]);
        end else begin
          frames_pend[d]--;
        end
        fc = frame_buf[d][0][2:0];
        if (mon_idx[d] == 5 && fc >= 3'd1 && fc <= 3'd5)
          rx_reg[d][fc] = {frame_buf[d][4], frame_buf[d][3], frame_buf[d][2], frame_buf[d][1]};
        else if (mon_idx[d] == 1 && fc == 3'd7)
          rx_en[d] = 1'b1;
        else if (mon_idx[d] == 1 && fc == 3'd6)
          rx_en[d] = 1'b0;
        mon_idx[d] = 0;
      end
      if (err[d]) begin
        compared++;
        if (err_pend[d] == 0) begin
          mismatched++;
          $display("FAIL err_pulse inst%0d: got err, required none", d);
        end else begin
          err_pend[d]--;
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("ready_timeout", d);
  endtask

  task automatic send(input int d, input logic [2:0] c, input logic [31:0] dat, input bit garbage);
    wait_ready(d);
    push_frame(d, c, dat);
    valid[d] = 1'b1;
    cmd[d]   = c;
    data[d]  = dat;
    @(negedge clk);
    valid[d] = 1'b0;
    if (c != 3'd0) check("busy_after_accept", d, busy[d], 32'h1);
    else           check("err_after_accept", d, err[d], 32'h1);
    if (garbage && c != 3'd0) begin
      valid[d] = 1'b1;
      cmd[d]   = 3'($urandom_range(0, 7));
      data[d]  = $urandom;
      check("ready_midframe", d, rdy[d], 32'h0);
      @(negedge clk);
      check("ready_midframe", d, rdy[d], 32'h0);
      valid[d] = 1'b0;
      data[d]  = $urandom;
    end
  endtask

  task automatic wait_done(input int d, input bit rnd);
    int n = 0;
    while ((frames_pend[d] != 0 || err_pend[d] != 0) && n < 1000) begin
      @(negedge clk);
      if (rnd) txr[d] = 1'($urandom_range(0, 1));
      n++;
    end
    txr[d] = 1'b1;
    if (n >= 1000) begin
      fail_now("frame_timeout", d);
      flush(d);
    end
  endtask

  task automatic do_reset(input int d);
    rst_l[d] = 1'b0;
    valid[d] = 1'b0;
    @(negedge clk);
    check("rst_dv", d, dv[d], 32'h0);
    check("rst_byte", d, txb[d], 32'h0);
    check("rst_busy", d, busy[d], 32'h0);
    check("rst_done", d, done[d], 32'h0);
    check("rst_err", d, err[d], 32'h0);
    check("rst_ready", d, rdy[d], 32'h1);
    flush(d);
    rst_l[d] = 1'b1;
  endtask

  task automatic count_dv(input int d, input int target);
    int n = 0;
    int k = 0;
    while (n < target && k < 300) begin
      @(negedge clk);
      if (dv[d]) n++;
      k++;
    end
    if (k >= 300) fail_now("dv_wait_timeout", d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] dat;
    logic [2:0]  c;
    bit          g;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    gap_min[0] = 2;
    gap_min[1] = 5;
    for (int d = 0; d < 2; d++) begin
      rst_l[d] = 1'b0;
      valid[d] = 1'b0;
      cmd[d]   = 3'd0;
      data[d]  = '0;
      txr[d]   = 1'b1;
      wr_p[d]  = 0;
      rd_p[d]  = 0;
      frames_pend[d] = 0;
      err_pend[d]    = 0;
      rdy_always[d]  = 1'b1;
      last_dv[d]     = 0;
      mon_idx[d]     = 0;
      rx_en[d]       = 1'b0;
      for (int r = 0; r < 8; r++) rx_reg[d][r] = '0;
    end
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // CV write, back-to-back bytes.
    send(0, 3'd1, 32'hDEADBEEF, 1'b0);
    wait_done(0, 1'b0);
    check("rx_counter_value", 0, rx_reg[0][1], 32'hDEADBEEF);
    send(1, 3'd1, 32'hDEADBEEF, 1'b0);
    wait_done(1, 1'b0);
    check("rx_counter_value", 1, rx_reg[1][1], 32'hDEADBEEF);

    // Single-byte control frames.
    send(0, 3'd7, $urandom, 1'b0);
    wait_done(0, 1'b0);
    check("rx_enable", 0, rx_en[0], 32'h1);
    send(0, 3'd6, $urandom, 1'b0);
    wait_done(0, 1'b0);
    check("rx_disable", 0, rx_en[0], 32'h0);

    // Invalid command.
    send(0, 3'd0, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_busy", 0, busy[0], 32'h0);
      check("err_no_dv", 0, dv[0], 32'h0);
    end
    wait_done(0, 1'b0);

    // Gap of 3 with the master stalling before the third byte.
    rdy_always[1] = 1'b0;
    dat = $urandom;
    send(1, 3'd4, dat, 1'b0);
    count_dv(1, 2);
    txr[1] = 1'b0;
    repeat (5) @(negedge clk);
    txr[1] = 1'b1;
    wait_done(1, 1'b0);
    check("rx_dc2", 1, rx_reg[1][4], dat);
    rdy_always[1] = 1'b1;

    // Reset after the second byte of a DC1 frame, then a clean PRESCALE frame.
    send(0, 3'd3, $urandom, 1'b0);
    count_dv(0, 2);
    do_reset(0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("dv_after_reset", 0, dv[0], 32'h0);
    end
    check("rx_dc1_aborted", 0, rx_reg[0][3], 32'h0);
    dat = $urandom;
    send(0, 3'd2, dat, 1'b0);
    wait_done(0, 1'b0);
    check("rx_prescale", 0, rx_reg[0][2], dat);

    // Request inputs changing mid-frame.
    for (int d = 0; d < 2; d++) begin
      dat = $urandom;
      send(d, 3'd5, dat, 1'b1);
      wait_done(d, 1'b0);
      check("rx_dc3_midframe", d, rx_reg[d][5], dat);
    end

    // Randomised traffic with a stalling master.
    for (int d = 0; d < 2; d++) begin
      rdy_always[d] = 1'b0;
      for (int i = 0; i < 20; i++) begin
        c   = 3'($urandom_range(0, 7));
        dat = $urandom;
        g   = 1'($urandom_range(0, 1));
        send(d, c, dat, g);
        wait_done(d, 1'b1);
        if (c >= 3'd1 && c <= 3'd5) check("rx_rand_reg", d, rx_reg[d][c], dat);
        else if (c == 3'd7)         check("rx_rand_en", d, rx_en[d], 32'h1);
        else if (c == 3'd6)         check("rx_rand_dis", d, rx_en[d], 32'h0);
      end
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
